vmu_spm_responder: RTL and testbench
====================================

Name: vmu_spm_responder

Overview:
- Scratchpad-memory (SPM) responder at the far end of the VMU's per-LSU SPM request interface.
- Accepts read/write requests from vmu_top's LSU ports (rden/wren/rdaddr/wraddr plus write data).
- Holds a single-ported-per-LSU word array and returns read data after a fixed pipeline latency.
- Used as the memory side of the vector pipeline and as the SPM model in VMU-level benches.

Parameters:
- NUM_LSU, 2, number of LSU request ports (matches SYS_NUM_LSU).
- SCALAR_WIDTH, 32, address width of each request.
- DATA_WIDTH, 64, word width.
- DEPTH, 1024, number of words; power of two, at least 2.
- MEMR_DELAY, 2, read latency in cycles; at least 1.
- MEMW_DELAY, 1, cycles from write request to array commit; at least 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- i_vmu_spm_rden[0:NUM_LSU-1]  in  1 each  read request, per port.
- i_vmu_spm_rdaddr[0:NUM_LSU-1]  in  SCALAR_WIDTH each  read word address.
- i_vmu_spm_wren[0:NUM_LSU-1]  in  1 each  write request.
- i_vmu_spm_wraddr[0:NUM_LSU-1]  in  SCALAR_WIDTH each  write word address.
- i_vmu_spm_wrdata[0:NUM_LSU-1]  in  DATA_WIDTH each  write data.
- o_spm_vmu_rdvld[0:NUM_LSU-1]  out  1 each  read data valid.
- o_spm_vmu_rddata[0:NUM_LSU-1]  out  DATA_WIDTH each  read data.
- o_spm_oor_err  out  1  out-of-range pulse.
- o_spm_wr_conflict  out  1  same-address multi-port write pulse.
- o_spm_oor_cnt  out  16  saturating out-of-range event count.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset state:
  - all rdvld = 0, rddata = 0, o_spm_oor_err = 0, o_spm_wr_conflict = 0, o_spm_oor_cnt = 0.
  - Read and write pipelines flushed; in-flight writes are dropped.
  - Array contents are not cleared.
  - Requests present in the reset cycle are ignored.
- No backpressure: each port accepts one read and one write every cycle. Full throughput is 1 read + 1 write per port per cycle.
- Read path:
  - rden[p] sampled high in cycle T with address A gives rdvld[p] = 1 in cycle T+MEMR_DELAY.
  - rddata[p] = array[A] as held before the commit edge ending cycle T.
  - Read-old semantics: a write committing on that same edge is not visible.
  - When rdvld = 0, rddata holds its last value.
- Write path:
  - wren[p] sampled in cycle T commits wrdata to array[wraddr] on the edge ending cycle T+MEMW_DELAY-1.
  - With MEMW_DELAY = 1, a read in cycle T+1 returns the new data.
  - Write data and address are pipelined with the request.
- Read/write on the same port in the same cycle: both proceed independently. Addresses may be equal; read-old rule applies.
- Write conflict:
  - Two or more writes commit to the same address on the same edge: the lowest port index wins.
  - o_spm_wr_conflict = 1 in the cycle after the commit edge; otherwise 0.
- Out of range (address ≥ DEPTH, i.e. nonzero bits above log2(DEPTH)):
  - Write: dropped.
  - Read: still returns rdvld after MEMR_DELAY, with rddata = 0.
  - o_spm_oor_err = 1 in cycle T+1 when any port issued an out-of-range request in cycle T.
  - o_spm_oor_cnt increments by 1 per such cycle, not per port, and saturates at 0xFFFF.
- Address arithmetic: the low log2(DEPTH) bits index the array; no wrap-around aliasing is permitted, because upper bits are checked.
- Latency is fixed; rdvld ordering per port equals request order.

Test Plan:
- Write/read latency, MEMR_DELAY=2, MEMW_DELAY=1: port0 wren, addr 128, data 0xDEAD_BEEF at cycle 10; rden addr 128 at cycle 11 -> rdvld[0]=1 at cycle 13, rddata=0xDEADBEEF, no other rdvld pulses.
- Read-old: array[5]=0x11; port0 write 0x22 to addr 5 and port1 read addr 5 in the same cycle T -> port1 returns 0x11 at T+2; a read at T+1 returns 0x22.
- Conflict: port0 writes 0xAA and port1 writes 0xBB to addr 7 in the same cycle -> o_spm_wr_conflict pulses once; a later read of addr 7 returns 0xAA.
- Out of range, DEPTH=1024: read addr 33333 -> rdvld after 2 cycles with rddata=0; o_spm_oor_err pulses and o_spm_oor_cnt=1. Write to 1024 leaves array[0] unchanged. Drive 70000 consecutive out-of-range cycles -> count saturates at 0xFFFF.
- Streaming: port0 and port1 issue rden every cycle for 16 cycles, addrs 0..15 -> rdvld is high for 16 consecutive cycles starting 2 cycles later, data in order.
- Reset mid-operation:
  - With MEMW_DELAY=3: issue a write at cycle T, assert rst at T+1 -> write lost, old data retained.
  - A read issued at T-1 produces no rdvld after reset.
  - All outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/vmu_spm_responder.sv
// SPM responder: per-LSU read/write ports onto one word array; reads return after MEMR_DELAY cycles,
// writes commit MEMW_DELAY-1 edges after the request. No backpressure; OOR and same-address writes flagged.
module vmu_spm_responder #(
    parameter int NUM_LSU      = 2,
    parameter int SCALAR_WIDTH = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 1024,
    parameter int MEMR_DELAY   = 2,
    parameter int MEMW_DELAY   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_vmu_spm_rden   [0:NUM_LSU-1],
    input  logic [SCALAR_WIDTH-1:0] i_vmu_spm_rdaddr [0:NUM_LSU-1],
    input  logic                    i_vmu_spm_wren   [0:NUM_LSU-1],
    input  logic [SCALAR_WIDTH-1:0] i_vmu_spm_wraddr [0:NUM_LSU-1],
    input  logic [DATA_WIDTH-1:0]   i_vmu_spm_wrdata [0:NUM_LSU-1],
    output logic                    o_spm_vmu_rdvld  [0:NUM_LSU-1],
    output logic [DATA_WIDTH-1:0]   o_spm_vmu_rddata [0:NUM_LSU-1],
    output logic                    o_spm_oor_err,
    output logic                    o_spm_wr_conflict,
    output logic [15:0]             o_spm_oor_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_oor [NUM_LSU];
    logic                  wr_oor [NUM_LSU];
    logic                  wr_ok  [NUM_LSU];
    logic                  any_oor;
    logic                  c_en   [NUM_LSU];
    logic [AW-1:0]         c_addr [NUM_LSU];
    logic [DATA_WIDTH-1:0] c_dat  [NUM_LSU];
    logic                  conflict;

    // Any set bit above the index field is out of range; no aliasing onto low words.
    always_comb begin
        any_oor = 1'b0;
        for (int p = 0; p < NUM_LSU; p++) begin
            rd_oor[p] = (i_vmu_spm_rdaddr[p] >> AW) != '0;
            wr_oor[p] = (i_vmu_spm_wraddr[p] >> AW) != '0;
            wr_ok[p]  = i_vmu_spm_wren[p] && !wr_oor[p];
            any_oor   = any_oor | (i_vmu_spm_rden[p] && rd_oor[p])
                                | (i_vmu_spm_wren[p] && wr_oor[p]);
        end
    end

    if (MEMW_DELAY == 1) begin : g_wr_direct
        always_comb begin
            for (int p = 0; p < NUM_LSU; p++) begin
                c_en[p]   = wr_ok[p];
                c_addr[p] = i_vmu_spm_wraddr[p][AW-1:0];
                c_dat[p]  = i_vmu_spm_wrdata[p];
            end
        end
    end else begin : g_wr_pipe
        localparam int NS = MEMW_DELAY - 1;
        logic                  en_q   [NS][NUM_LSU];
        logic [AW-1:0]         addr_q [NS][NUM_LSU];
        logic [DATA_WIDTH-1:0] dat_q  [NS][NUM_LSU];

        always_ff @(posedge clk) begin
            for (int p = 0; p < NUM_LSU; p++) begin
                en_q[0][p]   <= rst ? 1'b0 : wr_ok[p];
                addr_q[0][p] <= i_vmu_spm_wraddr[p][AW-1:0];
                dat_q[0][p]  <= i_vmu_spm_wrdata[p];
                for (int s = 1; s < NS; s++) begin
                    en_q[s][p]   <= rst ? 1'b0 : en_q[s-1][p];
                    addr_q[s][p] <= addr_q[s-1][p];
                    dat_q[s][p]  <= dat_q[s-1][p];
                end
            end
        end

        always_comb begin
            for (int p = 0; p < NUM_LSU; p++) begin
                c_en[p]   = en_q[NS-1][p];
                c_addr[p] = addr_q[NS-1][p];
                c_dat[p]  = dat_q[NS-1][p];
            end
        end
    end

    // Highest port written first so the lowest index lands last and wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = NUM_LSU - 1; p >= 0; p--) begin
                if (c_en[p]) mem[c_addr[p]] <= c_dat[p];
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_LSU; i++) begin
            for (int j = i + 1; j < NUM_LSU; j++) begin
                if (c_en[i] && c_en[j] && (c_addr[i] == c_addr[j])) conflict = 1'b1;
            end
        end
    end

    logic                  rv_q [MEMR_DELAY][NUM_LSU];
    logic [DATA_WIDTH-1:0] rd_q [MEMR_DELAY][NUM_LSU];

    // Data stages only load behind a valid, so the output holds its last value when idle.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_LSU; p++) begin
            if (rst) begin
                for (int s = 0; s < MEMR_DELAY; s++) begin
                    rv_q[s][p] <= 1'b0;
                    rd_q[s][p] <= '0;
                end
            end else begin
                rv_q[0][p] <= i_vmu_spm_rden[p];
                if (i_vmu_spm_rden[p])
                    rd_q[0][p] <= rd_oor[p] ? '0 : mem[i_vmu_spm_rdaddr[p][AW-1:0]];
                for (int s = 1; s < MEMR_DELAY; s++) begin
                    rv_q[s][p] <= rv_q[s-1][p];
                    if (rv_q[s-1][p]) rd_q[s][p] <= rd_q[s-1][p];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_LSU; p++) begin
            o_spm_vmu_rdvld[p]  = rv_q[MEMR_DELAY-1][p];
            o_spm_vmu_rddata[p] = rd_q[MEMR_DELAY-1][p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_spm_oor_err     <= 1'b0;
            o_spm_wr_conflict <= 1'b0;
            o_spm_oor_cnt     <= '0;
        end else begin
            o_spm_oor_err     <= any_oor;
            o_spm_wr_conflict <= conflict;
            if (any_oor && (o_spm_oor_cnt != 16'hFFFF))
                o_spm_oor_cnt <= o_spm_oor_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vmu_spm_responder.sv
// Bench for vmu_spm_responder: cycle model with a future-output ring checked every cycle,
// plus directed literal expectations; a second instance exercises a 3-cycle write commit.
module tb_vmu_spm_responder;
    localparam int          NL    = 2;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] PAT   = 64'hA5A5_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic        rden   [0:NL-1], wren   [0:NL-1], rdvld   [0:NL-1];
    logic [31:0] rdaddr [0:NL-1], wraddr [0:NL-1];
    logic [63:0] wrdata [0:NL-1], rddata [0:NL-1];
    logic        oor_err, wr_conflict;
    logic [15:0] oor_cnt;
    logic        rden3   [0:NL-1], wren3   [0:NL-1], rdvld3   [0:NL-1];
    logic [31:0] rdaddr3 [0:NL-1], wraddr3 [0:NL-1];
    logic [63:0] wrdata3 [0:NL-1], rddata3 [0:NL-1];
    logic        oor_err3, wr_conflict3;
    logic [15:0] oor_cnt3;

    vmu_spm_responder u_dut (
        .clk(clk), .rst(rst),
        .i_vmu_spm_rden(rden), .i_vmu_spm_rdaddr(rdaddr),
        .i_vmu_spm_wren(wren), .i_vmu_spm_wraddr(wraddr), .i_vmu_spm_wrdata(wrdata),
        .o_spm_vmu_rdvld(rdvld), .o_spm_vmu_rddata(rddata),
        .o_spm_oor_err(oor_err), .o_spm_wr_conflict(wr_conflict), .o_spm_oor_cnt(oor_cnt)
    );

    vmu_spm_responder #(.MEMW_DELAY(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .i_vmu_spm_rden(rden3), .i_vmu_spm_rdaddr(rdaddr3),
        .i_vmu_spm_wren(wren3), .i_vmu_spm_wraddr(wraddr3), .i_vmu_spm_wrdata(wrdata3),
        .o_spm_vmu_rdvld(rdvld3), .o_spm_vmu_rddata(rddata3),
        .o_spm_oor_err(oor_err3), .o_spm_wr_conflict(wr_conflict3), .o_spm_oor_cnt(oor_cnt3)
    );

    // Model of the main instance (read latency 2, write visible next cycle).
    logic [63:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    logic [15:0] m_cnt = '0;
    bit          r_set [8], r_rst [8], r_err [8], r_conf [8];
    logic [15:0] r_cnt [8];
    bit          r_vld [8][NL], r_known [8][NL];
    logic [63:0] r_dat [8][NL];
    logic [63:0] hold [NL];
    bit          hold_known [NL];

    int cyc = 0;
    int nvec = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Consumes this cycle's inputs; fills expectations for the next cycle and the read-return cycle.
    task automatic model_step();
        int n1, n2;
        bit any, conf;
        n1 = (cyc + 1) % 8;
        n2 = (cyc + 2) % 8;
        r_set[n2] = 0;
        r_rst[n2] = 0;
        for (int p = 0; p < NL; p++) begin
            r_vld[n2][p] = 0; r_known[n2][p] = 0; r_dat[n2][p] = '0;
        end
        r_set[n1] = 1;
        if (rst) begin
            r_rst[n1] = 1; r_err[n1] = 0; r_conf[n1] = 0;
            m_cnt = '0; r_cnt[n1] = '0;
            for (int p = 0; p < NL; p++) r_vld[n1][p] = 0;
            return;
        end
        r_rst[n1] = 0;
        any = 0;
        conf = 0;
        for (int p = 0; p < NL; p++) begin
            if (rden[p]) begin
                r_vld[n2][p] = 1;
                if (rdaddr[p] >= DEPTH) begin
                    any = 1; r_dat[n2][p] = '0; r_known[n2][p] = 1;
                end else begin
                    r_dat[n2][p]   = m_mem[rdaddr[p][9:0]];
                    r_known[n2][p] = m_known[rdaddr[p][9:0]];
                end
            end
            if (wren[p] && wraddr[p] >= DEPTH) any = 1;
        end
        for (int i = 0; i < NL; i++)
            for (int j = i + 1; j < NL; j++)
                if (wren[i] && wren[j] && wraddr[i] < DEPTH && wraddr[i] == wraddr[j]) conf = 1;
        for (int p = NL - 1; p >= 0; p--)
            if (wren[p] && wraddr[p] < DEPTH) begin
                m_mem[wraddr[p][9:0]]   = wrdata[p];
                m_known[wraddr[p][9:0]] = 1;
            end
        r_err[n1]  = any;
        r_conf[n1] = conf;
        if (any && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        r_cnt[n1] = m_cnt;
    endtask

    always @(negedge clk) begin : compare
        int k;
        k = cyc % 8;
        if (r_set[k]) begin
            for (int p = 0; p < NL; p++) begin
                if (r_rst[k]) begin hold[p] = '0; hold_known[p] = 1; end
                if (r_vld[k][p]) begin hold[p] = r_dat[k][p]; hold_known[p] = r_known[k][p]; end
                check($sformatf("model_rdvld%0d", p), rdvld[p], r_vld[k][p]);
                if (hold_known[p]) check($sformatf("model_rddata%0d", p), rddata[p], hold[p]);
            end
            check("model_oor_err", oor_err, r_err[k]);
            check("model_wr_conflict", wr_conflict, r_conf[k]);
            check("model_oor_cnt", oor_cnt, r_cnt[k]);
        end
    end

    task automatic clear_in();
        for (int p = 0; p < NL; p++) begin
            rden[p] = 0;  rdaddr[p] = '0;  wren[p] = 0;  wraddr[p] = '0;  wrdata[p] = '0;
            rden3[p] = 0; rdaddr3[p] = '0; wren3[p] = 0; wraddr3[p] = '0; wrdata3[p] = '0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        clear_in();
    endtask

    initial begin
        rst = 1; rst3 = 1;
        clear_in();
        repeat (3) tick();
        rst = 0; rst3 = 0;
        check("reset_vld", rdvld[0], 0);
        check("reset_cnt", oor_cnt, 0);
        while (cyc < 10) tick();

        // Write at 10, read at 11, data at 13.
        wren[0] = 1; wraddr[0] = 128; wrdata[0] = 64'hDEAD_BEEF; tick();
        rden[0] = 1; rdaddr[0] = 128; tick();
        check("lat_early", rdvld[0], 0);
        tick();
        check("lat_vld", rdvld[0], 1);
        check("lat_dat", rddata[0], 64'hDEAD_BEEF);
        check("lat_p1_quiet", rdvld[1], 0);

        // Read-old vs same-edge write.
        wren[0] = 1; wraddr[0] = 5; wrdata[0] = 64'h11; tick();
        wren[0] = 1; wraddr[0] = 5; wrdata[0] = 64'h22; rden[1] = 1; rdaddr[1] = 5; tick();
        rden[0] = 1; rdaddr[0] = 5; tick();
        check("rold_vld", rdvld[1], 1);
        check("rold_old", rddata[1], 64'h11);
        tick();
        check("rold_new", rddata[0], 64'h22);

        // Two ports writing one address.
        wren[0] = 1; wraddr[0] = 7; wrdata[0] = 64'hAA;
        wren[1] = 1; wraddr[1] = 7; wrdata[1] = 64'hBB; tick();
        check("conf_pulse", wr_conflict, 1);
        tick();
        check("conf_once", wr_conflict, 0);
        rden[1] = 1; rdaddr[1] = 7; tick(); tick();
        check("conf_win", rddata[1], 64'hAA);

        // Out of range read and write.
        rden[0] = 1; rdaddr[0] = 33333; tick();
        check("oor_err", oor_err, 1);
        check("oor_cnt1", oor_cnt, 1);
        tick();
        check("oor_vld", rdvld[0], 1);
        check("oor_dat", rddata[0], 0);
        check("oor_err_clr", oor_err, 0);
        wren[1] = 1; wraddr[1] = 0; wrdata[1] = 64'h1234; tick();
        wren[0] = 1; wraddr[0] = 1024; wrdata[0] = 64'h5555; tick();
        check("oor_wr_err", oor_err, 1);
        check("oor_cnt2", oor_cnt, 2);
        rden[0] = 1; rdaddr[0] = 0; tick(); tick();
        check("oor_wr_drop", rddata[0], 64'h1234);

        // Streaming reads on both ports.
        for (int i = 0; i < 16; i++) begin
            wren[0] = 1; wraddr[0] = 32'(i); wrdata[0] = PAT + 64'(i); tick();
        end
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                rden[0] = 1; rdaddr[0] = 32'(i);
                rden[1] = 1; rdaddr[1] = 32'(15 - i);
            end
            tick();
            if (i >= 1) begin
                check("stream_vld0", rdvld[0], 1);
                check("stream_dat0", rddata[0], PAT + 64'(i - 1));
                check("stream_vld1", rdvld[1], 1);
                check("stream_dat1", rddata[1], PAT + 64'(16 - i));
            end
        end
        tick();
        check("stream_end", rdvld[0], 0);

        // Reset with a read in flight and a write in the reset cycle.
        rden[0] = 1; rdaddr[0] = 3; tick();
        rst = 1; wren[1] = 1; wraddr[1] = 4; wrdata[1] = 64'hBAD; tick();
        rst = 0;
        check("rst_vld0", rdvld[0], 0);
        check("rst_dat0", rddata[0], 0);
        check("rst_dat1", rddata[1], 0);
        check("rst_cnt", oor_cnt, 0);
        rden[0] = 1; rdaddr[0] = 4; tick(); tick();
        check("rst_wr_ignored", rddata[0], PAT + 64'd4);

        // Three-cycle write commit instance.
        wren3[0] = 1; wraddr3[0] = 2; wrdata3[0] = 64'h77; tick(); tick(); tick();
        rden3[0] = 1; rdaddr3[0] = 2; tick(); tick();
        check("w3_vld", rdvld3[0], 1);
        check("w3_commit", rddata3[0], 64'h77);
        wren3[0] = 1; wraddr3[0] = 2; wrdata3[0] = 64'h99; tick(); tick();
        rden3[0] = 1; rdaddr3[0] = 2; tick();
        rden3[1] = 1; rdaddr3[1] = 2; tick();
        check("w3_old", rddata3[0], 64'h77);
        tick();
        check("w3_new", rddata3[1], 64'h99);
        wren3[1] = 1; wraddr3[1] = 2; wrdata3[1] = 64'hCC; tick();
        rst3 = 1; tick();
        rst3 = 0;
        check("w3_rst_vld", rdvld3[1], 0);
        check("w3_rst_dat", rddata3[1], 0);
        repeat (3) tick();
        rden3[0] = 1; rdaddr3[0] = 2; tick(); tick();
        check("w3_rst_lost", rddata3[0], 64'h99);

        // Counter saturation.
        for (int i = 0; i < 70000; i++) begin
            rden[1] = 1; rdaddr[1] = 32'(DEPTH + i); tick();
        end
        check("sat_cnt", oor_cnt, 16'hFFFF);
        check("sat_err", oor_err, 1);
        tick(); tick();
        check("sat_hold", oor_cnt, 16'hFFFF);
        check("sat_err_clr", oor_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
